// File: rtl/register_bank_16_pkg.sv
// ---------------------------------------------------------------------------
// register_bank_16_pkg
//   Shared constants and helpers for the 16-entry register bank.
//   - DATA_W_DEFAULT : default register / data-port width
//   - NUM_REGS_FIXED : register count, tied to the 16-bit decoder enable
//   - REG_IDX_W      : width of a register index / read address
//   - REG_RESET_VAL  : value every register and data output takes on reset
//   - index_mask()   : selects the one-hot positions whose index has a given
//                      bit set; used to encode a one-hot vector into an index
// ---------------------------------------------------------------------------
package register_bank_16_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NUM_REGS_FIXED = 16;
  localparam int REG_IDX_W      = 4;

  localparam logic [DATA_W_DEFAULT-1:0] REG_RESET_VAL = '0;

  // Bit k of the result is set when bit `bit_pos` of k is set. OR-reducing a
  // one-hot vector under this mask yields bit `bit_pos` of its index.
  function automatic logic [NUM_REGS_FIXED-1:0] index_mask(input int bit_pos);
    logic [NUM_REGS_FIXED-1:0] mask;
    mask = '0;
    for (int k = 0; k < NUM_REGS_FIXED; k++) begin
      mask[k] = ((k >> bit_pos) & 1) == 1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/register_bank_16_onehot_to_index.sv
// ---------------------------------------------------------------------------
// register_bank_16_onehot_to_index
//   Purely combinational one-hot encoder with an integrity flag.
//   Ports:
//     i_vec          : 16-bit enable vector from the destination decoder
//     o_index        : index of the set bit (meaningful only when valid)
//     o_valid_onehot : 1 when exactly one bit of i_vec is set
// ---------------------------------------------------------------------------
module register_bank_16_onehot_to_index
  import register_bank_16_pkg::*;
(
  input  logic [NUM_REGS_FIXED-1:0] i_vec,
  output logic [REG_IDX_W-1:0]      o_index,
  output logic                      o_valid_onehot
);

  // Prefix chains: w_any[k] = some bit below k is set,
  // w_multi[k] = at least two bits below k are set.
  logic [NUM_REGS_FIXED:0] w_any;
  logic [NUM_REGS_FIXED:0] w_multi;

  assign w_any[0]   = 1'b0;
  assign w_multi[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_REGS_FIXED; gi++) begin : g_chain
    assign w_any[gi+1]   = w_any[gi] | i_vec[gi];
    assign w_multi[gi+1] = w_multi[gi] | (w_any[gi] & i_vec[gi]);
  end

  assign o_valid_onehot = w_any[NUM_REGS_FIXED] & ~w_multi[NUM_REGS_FIXED];

  // Each index bit is the OR of the vector positions that have that bit set.
  for (genvar gi = 0; gi < REG_IDX_W; gi++) begin : g_index
    assign o_index[gi] = |(i_vec & index_mask(gi));
  end

endmodule

// File: rtl/register_bank_16.sv
// ---------------------------------------------------------------------------
// register_bank_16
//   16-entry general-purpose register file fed by a 4-to-16 destination
//   decoder with one cycle of latency. Write data is delayed one cycle to
//   line up with the decoder's registered one-hot enable; two registered
//   read ports forward a same-cycle commit; a sticky flag records any
//   qualified write whose enable was not exactly one-hot.
//   Ports:
//     clk        : clock, all state on posedge
//     rst        : asynchronous active-high reset
//     wr_req     : write request, same cycle the destination goes to decoder
//     wr_data    : write value, valid with wr_req
//     enable     : one-hot write enable from decoder, one cycle after wr_req
//     rd_addr_a  : read port A address
//     rd_addr_b  : read port B address
//     rd_data_a  : read port A data, one cycle after address
//     rd_data_b  : read port B data, one cycle after address
//     wr_commit  : one-cycle pulse per applied write
//     onehot_err : sticky non-one-hot enable flag, cleared only by reset
// ---------------------------------------------------------------------------
module register_bank_16
  import register_bank_16_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_FIXED,
  parameter int ZERO_R0  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_req,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [NUM_REGS_FIXED-1:0] enable,
  input  logic [REG_IDX_W-1:0]      rd_addr_a,
  input  logic [REG_IDX_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]         rd_data_a,
  output logic [DATA_W-1:0]         rd_data_b,
  output logic                      wr_commit,
  output logic                      onehot_err
);

  // The enable bus is hard-wired to 16 bits, so the bank size cannot vary.
  if (NUM_REGS != NUM_REGS_FIXED) begin : g_bad_num_regs
    $error("register_bank_16: NUM_REGS must be 16");
  end

  localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(REG_RESET_VAL);

  // -------------------------------------------------------------------------
  // Alignment stage: hold the request one cycle so it meets the decoder's
  // registered enable.
  // -------------------------------------------------------------------------
  logic              r_wr_req_q;
  logic [DATA_W-1:0] r_wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_req_q  <= 1'b0;
      r_wr_data_q <= RST_VAL;
    end else begin
      r_wr_req_q  <= wr_req;
      r_wr_data_q <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Commit decode. Enable is only meaningful while an aligned request is
  // pending; otherwise it is ignored completely.
  // -------------------------------------------------------------------------
  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_onehot;
  logic                 w_commit;
  logic                 w_bad_enable;

  register_bank_16_onehot_to_index u_onehot_to_index (
    .i_vec          (enable),
    .o_index        (w_idx),
    .o_valid_onehot (w_onehot)
  );

  assign w_commit     = r_wr_req_q & w_onehot;
  assign w_bad_enable = r_wr_req_q & ~w_onehot;

  // Per-register write strobes. With ZERO_R0 the strobe for entry 0 is
  // suppressed, but the commit itself (and its pulse) still happens.
  logic [NUM_REGS-1:0] w_reg_we;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
    if ((ZERO_R0 != 0) && (gi == 0)) begin : g_r0_hardwired
      assign w_reg_we[gi] = 1'b0;
    end else begin : g_r_writable
      assign w_reg_we[gi] = w_commit && (w_idx == REG_IDX_W'(gi));
    end
  end

  // -------------------------------------------------------------------------
  // Register array
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_reg_we[k]) begin
          r_regs[k] <= r_wr_data_q;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. A commit landing this cycle is forwarded so the read sees the
  // value the array will hold after the edge. Address 0 under ZERO_R0 wins
  // over the forward path.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_next_a;
  logic [DATA_W-1:0] w_rd_next_b;

  always_comb begin
    w_rd_next_a = r_regs[rd_addr_a];
    if (w_commit && (w_idx == rd_addr_a)) begin
      w_rd_next_a = r_wr_data_q;
    end
    if ((ZERO_R0 != 0) && (rd_addr_a == '0)) begin
      w_rd_next_a = RST_VAL;
    end
  end

  always_comb begin
    w_rd_next_b = r_regs[rd_addr_b];
    if (w_commit && (w_idx == rd_addr_b)) begin
      w_rd_next_b = r_wr_data_q;
    end
    if ((ZERO_R0 != 0) && (rd_addr_b == '0)) begin
      w_rd_next_b = RST_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= RST_VAL;
      rd_data_b <= RST_VAL;
    end else begin
      rd_data_a <= w_rd_next_a;
      rd_data_b <= w_rd_next_b;
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_commit  <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      wr_commit  <= w_commit;
      onehot_err <= onehot_err | w_bad_enable;
    end
  end

endmodule

// File: tb/tb_register_bank_16.sv
module tb_register_bank_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [15:0] enable;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b, rd_data_a_z, rd_data_b_z;
  logic        wr_commit, onehot_err, wr_commit_z, onehot_err_z;

  always #5 clk = ~clk;

  register_bank_16 #(.DATA_W(32), .NUM_REGS(16), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .enable(enable),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_commit(wr_commit), .onehot_err(onehot_err)
  );

  register_bank_16 #(.DATA_W(32), .NUM_REGS(16), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .enable(enable),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_z), .rd_data_b(rd_data_b_z),
    .wr_commit(wr_commit_z), .onehot_err(onehot_err_z)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents plus the pending write.
  logic [31:0] m_regs   [16];
  logic [31:0] m_regs_z [16];
  bit          m_req_q;
  logic [31:0] m_data_q;
  bit          m_err;
  logic [3:0]  m_prev_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      m_regs[k]   = '0;
      m_regs_z[k] = '0;
    end
    m_req_q     = 1'b0;
    m_data_q    = '0;
    m_err       = 1'b0;
    m_prev_dest = '0;
  endtask

  // One clock cycle, entered and left at a negedge. The bench plays the
  // decoder: enable is the one-hot of the previous cycle's destination unless
  // a forced pattern is supplied.
  task automatic cycle(input bit req, input logic [31:0] data, input logic [3:0] dest,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input bit frc, input logic [15:0] fen);
    bit          commit;
    int          idx;
    logic [31:0] ea, eb, eaz, ebz;
    wr_req    = req;
    wr_data   = data;
    rd_addr_a = ra;
    rd_addr_b = rb;
    enable    = frc ? fen : (16'h0001 << m_prev_dest);

    // Apply this cycle's write (if any) to the model, then read: a read of
    // the written register therefore sees the new value.
    commit = m_req_q && ($countones(enable) == 1);
    idx = 0;
    for (int k = 0; k < 16; k++) if (enable[k]) idx = k;
    if (m_req_q && !commit) m_err = 1'b1;
    if (commit) begin
      m_regs[idx] = m_data_q;
      if (idx != 0) m_regs_z[idx] = m_data_q;
    end
    ea  = m_regs[ra];
    eb  = m_regs[rb];
    eaz = (ra == 0) ? 32'h0 : m_regs_z[ra];
    ebz = (rb == 0) ? 32'h0 : m_regs_z[rb];
    m_req_q  = req;
    m_data_q = data;

    @(posedge clk);
    @(negedge clk);
    m_prev_dest = dest;

    $display("t=%0t req=%0d data=%h dest=%0d en=%h ra=%0d rb=%0d -> a=%h b=%h az=%h bz=%h commit=%0d err=%0d",
             $time, req, data, dest, enable, ra, rb, rd_data_a, rd_data_b,
             rd_data_a_z, rd_data_b_z, wr_commit, onehot_err);
    chk("rd_data_a", rd_data_a, ea);
    chk("rd_data_b", rd_data_b, eb);
    chk("rd_data_a_z0", rd_data_a_z, eaz);
    chk("rd_data_b_z0", rd_data_b_z, ebz);
    chk("wr_commit", {31'b0, wr_commit}, {31'b0, commit});
    chk("wr_commit_z0", {31'b0, wr_commit_z}, {31'b0, commit});
    chk("onehot_err", {31'b0, onehot_err}, {31'b0, m_err});
    chk("onehot_err_z0", {31'b0, onehot_err_z}, {31'b0, m_err});
  endtask

  // Assert reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    wr_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rd_a", rd_data_a, 32'h0);
    chk("rst_async_rd_b", rd_data_b, 32'h0);
    chk("rst_async_commit", {31'b0, wr_commit}, 32'h0);
    chk("rst_async_err", {31'b0, onehot_err}, 32'h0);
    chk("rst_async_rd_a_z0", rd_data_a_z, 32'h0);
    chk("rst_async_err_z0", {31'b0, onehot_err_z}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 4'(i), 4'(2*i), 4'(2*i+1), 1'b0, 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; enable = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    model_clear();

    // Reset state
    @(negedge clk);
    chk("reset_rd_a", rd_data_a, 32'h0);
    chk("reset_rd_b", rd_data_b, 32'h0);
    chk("reset_commit", {31'b0, wr_commit}, 32'h0);
    chk("reset_err", {31'b0, onehot_err}, 32'h0);
    rst = 1'b0;

    // Write latency: write r5 in cycle 0, read in cycle 2
    cycle(1'b1, 32'hDEADBEEF, 4'd5, 4'd0, 4'd0, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd5, 4'd5, 1'b0, 16'h0);

    // Bypass: request r7 in cycle 0 (old value read), commit in cycle 1 (forwarded)
    cycle(1'b1, 32'h12345678, 4'd7, 4'd5, 4'd7, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd7, 4'd7, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd7, 4'd5, 1'b0, 16'h0);

    // Idle enable: decoder cycles every destination, no requests
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, $urandom, 4'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 16'h0);
    end

    // One-hot fault with two bits set, then observe the flag holding
    cycle(1'b1, 32'hAAAA5555, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0003);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0);

    // Preload then reset mid-cycle
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0DE0000 + i, 4'(i), 4'd5, 4'd7, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd1, 4'd7, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd2, 4'd5, 1'b0, 16'h0);
    do_reset();
    read_all();

    // One-hot fault with no bits set
    cycle(1'b1, 32'h55AA55AA, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0);
    do_reset();

    // Streaming: 16 back-to-back writes, then read pairs (i, 15-i)
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + i, 4'(i), 4'd0, 4'd15, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 4'd0, 4'(i), 4'(15 - i), 1'b0, 16'h0);

    // Same register written back-to-back: last write wins
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hBEEF0000 + i, 4'd9, 4'd9, 4'd0, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd9, 4'd9, 1'b0, 16'h0);
    cycle(1'b0, 32'h0, 4'd0, 4'd9, 4'd0, 1'b0, 16'h0);

    // Random traffic with well-formed enables
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 16'h0);
    end

    // Random traffic with occasional arbitrary enables
    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0), 16'($urandom));
    end

    do_reset();
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_16.md
Name: register_bank_16

Overview:
- 16-entry general-purpose register file. Sits directly downstream of the 4-to-16 destination decoder and consumes its registered one-hot write enable.
- Provides write-data alignment for the decoder's one-cycle latency, two registered read ports with write-through bypass, and one-hot integrity checking.
- Feeds operand values to the execute stage.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- NUM_REGS, 16, number of registers. Fixed by the 16-bit decoder enable; any other value is a elaboration error.
- ZERO_R0, 0, when 1, register 0 reads as zero and writes to it are discarded.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- wr_req  input  1  write request, asserted in the same cycle the destination code is presented to the decoder.
- wr_data  input  DATA_W  write value, valid with wr_req.
- enable  input  16  one-hot write enable from the decoder; valid one cycle after the matching dest/wr_req.
- rd_addr_a  input  4  read port A address.
- rd_addr_b  input  4  read port B address.
- rd_data_a  output  DATA_W  read port A data, registered.
- rd_data_b  output  DATA_W  read port B data, registered.
- wr_commit  output  1  pulses one cycle when a write is applied to the array.
- onehot_err  output  1  sticky; set when a qualified write sees a non-one-hot enable.

Behaviour:
- Reset (async, rst=1): all registers, wr_req_q, wr_data_q, rd_data_a/b, wr_commit and onehot_err go to 0 immediately. Outputs stay 0 while rst is held. First edge after deassertion behaves as normal operation.
- Alignment stage, cycle N: wr_req and wr_data are captured into wr_req_q and wr_data_q.
- Commit, cycle N+1: when wr_req_q=1 and enable is exactly one-hot, the register at the index of the set bit takes wr_data_q at the edge closing N+1. The new value is readable from the array in cycle N+2.
- wr_commit is registered and is high during cycle N+2 for each applied write.
- The decoder drives enable every cycle. With wr_req_q=0, enable is ignored entirely: no write, no error.
- Non-one-hot enable (zero bits, or two or more bits set) with wr_req_q=1: no register is written, wr_commit stays 0, onehot_err sets to 1 and holds until reset.
- Reads: rd_addr_x sampled in cycle M; rd_data_x valid in cycle M+1. One-cycle latency on both ports, fully independent; A and B may address the same register.
- Bypass: in cycle M, if a commit is occurring and the enable index equals rd_addr_x, rd_data_x in M+1 equals wr_data_q, not the stale array value.
- No bypass is taken from the alignment stage. A write requested in cycle M is not visible to a read issued in cycle M.
- ZERO_R0=1: reads of address 0 return 0, including through the bypass path. A commit to index 0 still pulses wr_commit but leaves the array unchanged.
- Back-to-back writes, one per cycle, are sustained with no stalls. Consecutive writes to the same register: the last write wins.
- Throughput: one write and two reads per cycle.

Decomposition:
- Shared package: DATA_W default, NUM_REGS=16, REG_IDX_W=4, reset value constant (all zeros).
- Sub-module onehot_to_index: combinational; 16-bit input to a 4-bit index plus a valid_onehot flag. Reused by the commit logic and the error detection.

Test Plan:
- Reset: preload registers, assert rst mid-cycle -> rd_data_a/b, wr_commit and onehot_err drop to 0 without waiting for a clock edge; all registers read 0 afterwards.
- Write latency: wr_req=1, wr_data=0xDEADBEEF with decoder dest=5 in cycle 0 -> wr_commit=1 in cycle 2; rd_addr_a=5 in cycle 2 -> rd_data_a=0xDEADBEEF in cycle 3.
- Bypass: commit to r7 of 0x12345678 in cycle 1 with rd_addr_b=7 in cycle 1 -> rd_data_b=0x12345678 in cycle 2; same read issued in cycle 0 returns the old r7 value.
- Idle enable: wr_req=0 for 20 cycles with the decoder cycling dest 0..15 -> no register changes, wr_commit stays 0, onehot_err stays 0.
- One-hot fault: force enable=16'h0003 with wr_req_q=1 -> r0 and r1 unchanged, wr_commit=0, onehot_err=1 and held until rst; repeat with enable=16'h0000, same result.
- Streaming: 16 back-to-back writes r0..r15 with values 0x100+i, then read pairs (i, 15-i) -> every read returns its written value. With ZERO_R0=1, address 0 reads 0.
